// File: rtl/stage_d_writeback_buffered_pkg.sv
// Shared opcode definitions for the A-D pipeline stages.
package stage_d_writeback_buffered_pkg;

  localparam int OPCODE_MSB = 3;

  typedef enum logic [OPCODE_MSB:0] {
    OP_NOP    = 4'd0,
    OP_ALU    = 4'd1,
    OP_LOAD   = 4'd2,
    OP_STORE  = 4'd3,
    OP_BRANCH = 4'd4
  } opcode_e;

endpackage

// File: rtl/stage_d_writeback_buffered_wb_write_fifo.sv
// Posted-write buffer: ordered storage of pending data-memory writes with
// optional newest-entry coalescing and a newest-match forwarding lookup.
module wb_write_fifo #(
  parameter int A_WIDTH  = 12,
  parameter int D_WIDTH  = 8,
  parameter int DEPTH    = 4,
  parameter int COALESCE = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [A_WIDTH-1:0]           push_addr,
  input  logic [D_WIDTH-1:0]           push_data,
  input  logic                         pop,
  output logic [A_WIDTH-1:0]           head_addr,
  output logic [D_WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic [A_WIDTH-1:0]           fwd_addr,
  output logic                         fwd_hit,
  output logic [D_WIDTH-1:0]           fwd_data
);
  import stage_d_writeback_buffered_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [A_WIDTH-1:0] addr_q [DEPTH];
  logic [D_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr, tail_ptr;
  logic               merge, alloc;

  assign tail_ptr = wr_ptr - PTR_W'(1);

  // The tail may only absorb a write if it is not the entry leaving this cycle.
  assign merge = (COALESCE != 0) && push && (count != '0) &&
                 (addr_q[tail_ptr] == push_addr) &&
                 !(pop && (count == CNT_W'(1)));
  assign alloc = push && !merge;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (alloc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({alloc, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end else if (merge) begin
      data_q[tail_ptr] <= push_data;
    end
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // Walk oldest to newest so a later match overrides an earlier one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr_q[idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/stage_d_writeback_buffered.sv
// Final pipeline stage: registers the retiring opcode and posts data-memory
// writes into a drain buffer with forwarding to earlier stages.
module stage_d_writeback_buffered #(
  parameter int A_WIDTH  = 12,
  parameter int D_WIDTH  = 8,
  parameter int DEPTH    = 4,
  parameter int COALESCE = 1
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [stage_d_writeback_buffered_pkg::OPCODE_MSB:0]    operation_in,
  input  logic                                                   valid_in,
  output logic                                                   ready_out,
  input  logic                                                   wr_in,
  input  logic [A_WIDTH-1:0]                                     dp,
  input  logic [D_WIDTH-1:0]                                     d_in,
  output logic [stage_d_writeback_buffered_pkg::OPCODE_MSB:0]    operation,
  output logic                                                   valid_out,
  input  logic                                                   ready_in,
  output logic                                                   dce,
  output logic [A_WIDTH-1:0]                                     da,
  output logic [D_WIDTH-1:0]                                     dq,
  input  logic                                                   dack,
  input  logic [A_WIDTH-1:0]                                     fwd_addr,
  output logic                                                   fwd_hit,
  output logic [D_WIDTH-1:0]                                     fwd_data,
  output logic [$clog2(DEPTH+1)-1:0]                             count
);
  import stage_d_writeback_buffered_pkg::*;

  localparam int CNT_W = $clog2(DEPTH+1);

  logic accept, push, pop;

  // Backpressure depends only on downstream ready and buffer occupancy.
  assign ready_out = (!valid_out || ready_in) && (count != CNT_W'(DEPTH));
  assign accept    = valid_in && ready_out;
  assign push      = accept && wr_in;
  assign dce       = (count != '0);
  assign pop       = dce && dack;

  always_ff @(posedge clk) begin
    if (reset) begin
      operation <= '0;
      valid_out <= 1'b0;
    end else if (accept) begin
      operation <= operation_in;
      valid_out <= 1'b1;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

  wb_write_fifo #(
    .A_WIDTH  (A_WIDTH),
    .D_WIDTH  (D_WIDTH),
    .DEPTH    (DEPTH),
    .COALESCE (COALESCE)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (dp),
    .push_data (d_in),
    .pop       (pop),
    .head_addr (da),
    .head_data (dq),
    .count     (count),
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
  );

endmodule
